// File: rtl/pipe_skid_reg.sv
// Two-entry elastic pipeline register with registered back-pressure.
// Holds up to two words between pipeline stages and keeps full throughput.
//
// Ports:
//   clk, rst_n   clock; synchronous active-low reset
//   flush        discard all held words
//   in_valid     producer offers in_data
//   in_ready     block can accept a word
//   in_data      producer word
//   out_valid    out_data holds a valid word
//   out_ready    consumer accepts out_data
//   out_data     oldest held word
//   occupancy    words held (0..2)
//   xfer_cnt     completed output transfers, wrapping
module pipe_skid_reg #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] xfer_cnt
);

  // The encoding equals the word count, so occupancy is the state itself.
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic in_fire;
  logic out_fire;
  logic is_empty;
  logic is_one;
  logic is_two;

  assign is_empty = (state_q == S_EMPTY);
  assign is_one   = (state_q == S_ONE);
  assign is_two   = (state_q == S_TWO);

  // Every output comes straight from a flop: no in->out path.
  assign out_valid = !is_empty;
  assign in_ready  = !is_two;
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign xfer_cnt  = cnt_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;
    if (flush) begin
      // Data regs are kept so out_data stays at its last value.
      state_d = S_EMPTY;
    end else begin
      if (out_fire) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      unique case (1'b1)
        is_empty: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = S_ONE;
          end
        end
        is_one: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = S_TWO;
          end else if (out_fire) begin
            state_d = S_EMPTY;
          end
        end
        is_two: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = S_ONE;
          end
        end
        default: begin
          state_d = S_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Testbench for pipe_skid_reg: directed table, streaming, counter wrap
// and random traffic against a queue-based reference model.
module tb_pipe_skid_reg;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  occupancy;
  logic [15:0] xfer_cnt;

  logic        w_in_ready;
  logic        w_out_valid;
  logic [15:0] w_out_data;
  logic [1:0]  w_occupancy;
  logic [3:0]  w_xfer_cnt;

  int nvec;
  int nerr;

  pipe_skid_reg #(.WIDTH(16), .CNT_W(16)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .xfer_cnt  (xfer_cnt)
  );

  // Narrow-counter copy sharing the same stimulus, used for wrap checks.
  pipe_skid_reg #(.WIDTH(16), .CNT_W(4)) u_wrap (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (w_in_ready),
    .in_data   (in_data),
    .out_valid (w_out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_data),
    .occupancy (w_occupancy),
    .xfer_cnt  (w_xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a FIFO of held words plus a transfer count.
  logic [15:0] mq[$];
  int unsigned mcnt;
  logic [15:0] mlast;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic f,
                              input logic iv, input logic [15:0] d,
                              input logic ordy);
    bit acc;
    bit give;
    if (!r) begin
      mq.delete();
      mcnt  = 0;
      mlast = 16'h0;
    end else if (f) begin
      if (mq.size() > 0) mlast = mq[0];
      mq.delete();
    end else begin
      acc  = iv && (mq.size() < 2);
      give = ordy && (mq.size() > 0);
      if (give) begin
        void'(mq.pop_front());
        mcnt++;
      end
      if (acc) mq.push_back(d);
      if (mq.size() > 0) mlast = mq[0];
    end
  endtask

  task automatic check_model();
    logic [15:0] exp_d;
    int          sz;
    sz    = mq.size();
    exp_d = (sz > 0) ? mq[0] : mlast;
    chk("out_valid", 32'(out_valid), 32'(sz > 0));
    chk("in_ready",  32'(in_ready),  32'(sz < 2));
    chk("occupancy", 32'(occupancy), 32'(sz));
    chk("out_data",  32'(out_data),  32'(exp_d));
    chk("xfer_cnt",  32'(xfer_cnt),  32'(mcnt & 32'hFFFF));
    chk("wrap_cnt",  32'(w_xfer_cnt), 32'(mcnt & 32'hF));
  endtask

  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [15:0] d, input logic ordy);
    rst_n     = r;
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(posedge clk);
    model_update(r, f, iv, d, ordy);
    #1;
    check_model();
  endtask

  typedef struct {
    logic        r;
    logic        f;
    logic        iv;
    logic [15:0] d;
    logic        ordy;
    logic        e_ov;
    logic        e_ir;
    logic [1:0]  e_occ;
    logic [15:0] e_d;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[17];

  initial begin
    nvec = 0;
    nerr = 0;
    mcnt = 0;
    mlast = 16'h0;
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = 16'h0;
    out_ready = 1'b0;

    //          r     f     iv    d         or    ov    ir    occ   data      cnt
    // reset held two cycles
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 2'd0, 16'h0000, 16'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 2'd0, 16'h0000, 16'd0};
    // stall: AAAA, BBBB taken, CCCC held off, then drain
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 16'hAAAA, 1'b0, 1'b1, 1'b1, 2'd1, 16'hAAAA, 16'd0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 16'hBBBB, 1'b0, 1'b1, 1'b0, 2'd2, 16'hAAAA, 16'd0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 16'hCCCC, 1'b0, 1'b1, 1'b0, 2'd2, 16'hAAAA, 16'd0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 16'hCCCC, 1'b1, 1'b1, 1'b1, 2'd1, 16'hBBBB, 16'd1};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 16'hCCCC, 1'b1, 1'b1, 1'b1, 2'd1, 16'hCCCC, 16'd2};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 2'd0, 16'hCCCC, 16'd3};
    // flush at TWO with traffic offered on both sides
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 16'h1111, 1'b0, 1'b1, 1'b1, 2'd1, 16'h1111, 16'd3};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 16'h2222, 1'b0, 1'b1, 1'b0, 2'd2, 16'h1111, 16'd3};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 16'h3333, 1'b1, 1'b0, 1'b1, 2'd0, 16'h1111, 16'd3};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 2'd0, 16'h1111, 16'd3};
    // reset mid-stream at TWO (reset beats flush), then a lone word
    tbl[12] = '{1'b1, 1'b0, 1'b1, 16'h4444, 1'b0, 1'b1, 1'b1, 2'd1, 16'h4444, 16'd3};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b1, 1'b0, 2'd2, 16'h4444, 16'd3};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 16'h6666, 1'b1, 1'b0, 1'b1, 2'd0, 16'h0000, 16'd0};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 16'h5A5A, 1'b0, 1'b1, 1'b1, 2'd1, 16'h5A5A, 16'd0};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 2'd0, 16'h5A5A, 16'd1};

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      chk($sformatf("tbl%0d_ov", i),  32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_ir", i),  32'(in_ready),  32'(tbl[i].e_ir));
      chk($sformatf("tbl%0d_occ", i), 32'(occupancy), 32'(tbl[i].e_occ));
      chk($sformatf("tbl%0d_d", i),   32'(out_data),  32'(tbl[i].e_d));
      chk($sformatf("tbl%0d_cnt", i), 32'(xfer_cnt),  32'(tbl[i].e_cnt));
    end

    // Streaming 1..16 from reset; narrow counter wraps on the 16th.
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, 1'b0, 1'b1, 16'(k), 1'b1);
      chk("stream_data", 32'(out_data), 32'(k));
      chk("stream_ir",   32'(in_ready), 32'd1);
      chk("stream_cnt",  32'(xfer_cnt), 32'(k - 1));
    end
    chk("wrap_pre", 32'(w_xfer_cnt), 32'd15);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    chk("stream_total", 32'(xfer_cnt), 32'd16);
    chk("wrap_zero",    32'(w_xfer_cnt), 32'd0);
    chk("stream_empty", 32'(out_valid), 32'd0);

    // Random traffic with rare flushes and resets.
    for (int n = 0; n < 4000; n++) begin
      step(($urandom_range(0, 299) != 0),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 3) != 0),
           16'($urandom),
           ($urandom_range(0, 2) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
